ex_mem_pipe: RTL and testbench

- Parametrised EX/MEM pipeline register. Carries N write-back lanes (dest address, write enable, write data) from the execute stage to the memory-access stage.
- Adds a valid/ready handshake, a 2-entry skid buffer for full-throughput backpressure, synchronous flush, and a same-cycle lane write-collision filter.
- Sits between the execute unit and the memory-access stage. It is the drop-in successor to the single-lane EX/MEM latch.

---
 rtl/ex_mem_pipe_if.sv | 28 ++
 rtl/ex_mem_pipe.sv | 151 +++++++++++++++
 tb/tb_ex_mem_pipe.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_pipe_if.sv
// Bundle of execute-side and memory-side handshake/lane signals around the EX/MEM register.
// master: execute producer plus memory consumer; slave: the pipeline register itself.
interface ex_mem_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = 1
);
  logic                     ex_valid;
  logic                     ex_ready;
  logic [LANES*ADDR_W-1:0]  ex_wd;
  logic [LANES-1:0]         ex_wreg;
  logic [LANES*DATA_W-1:0]  ex_wdata;
  logic                     mem_valid;
  logic                     mem_ready;
  logic [LANES*ADDR_W-1:0]  mem_wd;
  logic [LANES-1:0]         mem_wreg;
  logic [LANES*DATA_W-1:0]  mem_wdata;

  modport master (
    output ex_valid, ex_wd, ex_wreg, ex_wdata, mem_ready,
    input  ex_ready, mem_valid, mem_wd, mem_wreg, mem_wdata
  );

  modport slave (
    input  ex_valid, ex_wd, ex_wreg, ex_wdata, mem_ready,
    output ex_ready, mem_valid, mem_wd, mem_wreg, mem_wdata
  );
endinterface

// File: rtl/ex_mem_pipe.sv
// Multi-lane EX/MEM pipeline register with skid buffer, flush and lane write-collision filter.
// Optional saturating backpressure counter enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  ex_mem_pipe_if.slave  bus
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int WD_W    = LANES * ADDR_W;
  localparam int WDATA_W = LANES * DATA_W;

  logic                m_valid_r, m_valid_s;
  logic [WD_W-1:0]     m_wd_r, m_wd_s;
  logic [LANES-1:0]    m_wreg_r, m_wreg_s;
  logic [WDATA_W-1:0]  m_wdata_r, m_wdata_s;

  logic                s_valid_r, s_valid_s;
  logic [WD_W-1:0]     s_wd_r, s_wd_s;
  logic [LANES-1:0]    s_wreg_r, s_wreg_s;
  logic [WDATA_W-1:0]  s_wdata_r, s_wdata_s;

  logic                ex_ready_r, ex_ready_s;
  logic                in_xfer_s, out_xfer_s;
  logic [LANES-1:0]    in_wreg_s;

  // A lower lane loses its write enable when a higher enabled lane targets the same address.
  function automatic logic [LANES-1:0] filter_wreg(input logic [WD_W-1:0]  wd,
                                                   input logic [LANES-1:0] wreg);
    logic [LANES-1:0] keep;
    keep = wreg;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        keep[i] = keep[i] & ~(wreg[i] & wreg[j] &
                              (wd[i*ADDR_W +: ADDR_W] == wd[j*ADDR_W +: ADDR_W]));
      end
    end
    return keep;
  endfunction

  assign in_xfer_s  = bus.ex_valid & ex_ready_r;
  assign out_xfer_s = m_valid_r & bus.mem_ready;
  assign in_wreg_s  = filter_wreg(bus.ex_wd, bus.ex_wreg);

  // Next-state selection for main and skid registers.
  always_comb begin
    m_valid_s = m_valid_r;
    m_wd_s    = m_wd_r;
    m_wreg_s  = m_wreg_r;
    m_wdata_s = m_wdata_r;
    s_valid_s = s_valid_r;
    s_wd_s    = s_wd_r;
    s_wreg_s  = s_wreg_r;
    s_wdata_s = s_wdata_r;
    if (flush) begin
      m_valid_s = 1'b0;
      m_wd_s    = {WD_W{1'b0}};
      m_wreg_s  = {LANES{1'b0}};
      m_wdata_s = {WDATA_W{1'b0}};
      s_valid_s = 1'b0;
    end else if (!m_valid_r || out_xfer_s) begin
      // The skid entry is older than anything on the input, so it drains first.
      if (s_valid_r) begin
        m_valid_s = 1'b1;
        m_wd_s    = s_wd_r;
        m_wreg_s  = s_wreg_r;
        m_wdata_s = s_wdata_r;
        s_valid_s = 1'b0;
      end else if (in_xfer_s) begin
        m_valid_s = 1'b1;
        m_wd_s    = bus.ex_wd;
        m_wreg_s  = in_wreg_s;
        m_wdata_s = bus.ex_wdata;
      end else begin
        m_valid_s = 1'b0;
        m_wd_s    = {WD_W{1'b0}};
        m_wreg_s  = {LANES{1'b0}};
        m_wdata_s = {WDATA_W{1'b0}};
      end
    end else begin
      if (in_xfer_s) begin
        s_valid_s = 1'b1;
        s_wd_s    = bus.ex_wd;
        s_wreg_s  = in_wreg_s;
        s_wdata_s = bus.ex_wdata;
      end else begin
        s_valid_s = s_valid_r;
      end
    end
    ex_ready_s = ~s_valid_s;
  end

  // Pipeline state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_r  <= 1'b0;
      m_wd_r     <= {WD_W{1'b0}};
      m_wreg_r   <= {LANES{1'b0}};
      m_wdata_r  <= {WDATA_W{1'b0}};
      s_valid_r  <= 1'b0;
      s_wd_r     <= {WD_W{1'b0}};
      s_wreg_r   <= {LANES{1'b0}};
      s_wdata_r  <= {WDATA_W{1'b0}};
      ex_ready_r <= 1'b1;
    end else begin
      m_valid_r  <= m_valid_s;
      m_wd_r     <= m_wd_s;
      m_wreg_r   <= m_wreg_s;
      m_wdata_r  <= m_wdata_s;
      s_valid_r  <= s_valid_s;
      s_wd_r     <= s_wd_s;
      s_wreg_r   <= s_wreg_s;
      s_wdata_r  <= s_wdata_s;
      ex_ready_r <= ex_ready_s;
    end
  end

  assign bus.ex_ready  = ex_ready_r;
  assign bus.mem_valid = m_valid_r;
  assign bus.mem_wd    = m_wd_r;
  assign bus.mem_wreg  = m_wreg_r;
  assign bus.mem_wdata = m_wdata_r;

`ifdef EX_MEM_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of edges where the consumer refused a held bundle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (flush) begin
      stall_cnt_r <= 16'h0000;
    end else if (m_valid_r && !bus.mem_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed self-checking bench for ex_mem_pipe: a single-lane and a two-lane instance.
// Define EX_MEM_STALL_CNT_EN to also exercise the stall counter.
module tb_ex_mem_pipe;

  logic clk;
  logic rst;
  logic flush;
  int   errors;
  int   checks;

  ex_mem_pipe_if #(.DATA_W(32), .ADDR_W(5), .LANES(1)) bus1 ();
  ex_mem_pipe_if #(.DATA_W(32), .ADDR_W(5), .LANES(2)) bus2 ();

`ifdef EX_MEM_STALL_CNT_EN
  logic [15:0] stall_cnt1;
  logic [15:0] stall_cnt2;
`endif

  ex_mem_pipe #(.DATA_W(32), .ADDR_W(5), .LANES(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus1)
`ifdef EX_MEM_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt1)
`endif
  );

  ex_mem_pipe #(.DATA_W(32), .ADDR_W(5), .LANES(2)) u_dut2 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus2)
`ifdef EX_MEM_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [4:0] wd, input logic [31:0] wdata);
    bus1.ex_valid = 1'b1;
    bus1.ex_wd    = wd;
    bus1.ex_wreg  = 1'b1;
    bus1.ex_wdata = wdata;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    flush  = 1'b0;
    bus1.ex_valid = 1'b0; bus1.ex_wd = 5'd0; bus1.ex_wreg = 1'b0; bus1.ex_wdata = 32'd0;
    bus1.mem_ready = 1'b0;
    bus2.ex_valid = 1'b0; bus2.ex_wd = 10'd0; bus2.ex_wreg = 2'b00; bus2.ex_wdata = 64'd0;
    bus2.mem_ready = 1'b0;

    // Reset held while inputs toggle randomly
    for (int k = 0; k < 3; k++) begin
      bus1.ex_valid  = 1'($urandom_range(0, 1));
      bus1.ex_wd     = 5'($urandom);
      bus1.ex_wreg   = 1'($urandom_range(0, 1));
      bus1.ex_wdata  = $urandom;
      bus1.mem_ready = 1'($urandom_range(0, 1));
      bus2.ex_valid  = 1'($urandom_range(0, 1));
      bus2.ex_wd     = 10'($urandom);
      bus2.ex_wreg   = 2'($urandom);
      bus2.ex_wdata  = {$urandom, $urandom};
      flush          = 1'($urandom_range(0, 1));
      step();
      check("rst_mem_valid", 64'(bus1.mem_valid), 64'd0);
      check("rst_mem_wreg",  64'(bus1.mem_wreg),  64'd0);
      check("rst_mem_wd",    64'(bus1.mem_wd),    64'd0);
      check("rst_mem_wdata", 64'(bus1.mem_wdata), 64'd0);
      check("rst_ex_ready",  64'(bus1.ex_ready),  64'd1);
      check("rst2_mem_valid", 64'(bus2.mem_valid), 64'd0);
    end

    flush = 1'b0;
    bus1.ex_valid = 1'b0; bus1.ex_wreg = 1'b0;
    bus2.ex_valid = 1'b0; bus2.ex_wreg = 2'b00; bus2.mem_ready = 1'b1;
    rst = 1'b1;

    // Latency and back-to-back throughput
    bus1.mem_ready = 1'b1;
    push1(5'd3, 32'h1234);
    step();
    check("lat_a_valid", 64'(bus1.mem_valid), 64'd1);
    check("lat_a_wd",    64'(bus1.mem_wd),    64'd3);
    check("lat_a_wreg",  64'(bus1.mem_wreg),  64'd1);
    check("lat_a_wdata", 64'(bus1.mem_wdata), 64'h1234);
    check("lat_a_ready", 64'(bus1.ex_ready),  64'd1);
    push1(5'd7, 32'h5678);
    step();
    check("lat_b_valid", 64'(bus1.mem_valid), 64'd1);
    check("lat_b_wd",    64'(bus1.mem_wd),    64'd7);
    check("lat_b_wdata", 64'(bus1.mem_wdata), 64'h5678);
    check("lat_b_ready", 64'(bus1.ex_ready),  64'd1);
    bus1.ex_valid = 1'b0;
    step();
    check("bubble_valid", 64'(bus1.mem_valid), 64'd0);
    check("bubble_wreg",  64'(bus1.mem_wreg),  64'd0);
    check("bubble_wd",    64'(bus1.mem_wd),    64'd0);
    check("bubble_wdata", 64'(bus1.mem_wdata), 64'd0);

    // Backpressure: A and B fill M and S, C waits, then drain in order
    bus1.mem_ready = 1'b0;
    push1(5'd1, 32'd1);
    step();
    check("bp_a_ready", 64'(bus1.ex_ready), 64'd1);
    push1(5'd2, 32'd2);
    step();
    check("bp_full_ready", 64'(bus1.ex_ready),  64'd0);
    check("bp_full_mem",   64'(bus1.mem_wdata), 64'd1);
    push1(5'd4, 32'd3);
    step();
    check("bp_c_blocked", 64'(bus1.ex_ready),  64'd0);
    check("bp_c_mem",     64'(bus1.mem_wdata), 64'd1);
    bus1.mem_ready = 1'b1;
    step();
    check("bp_b_out",   64'(bus1.mem_wdata), 64'd2);
    check("bp_b_valid", 64'(bus1.mem_valid), 64'd1);
    check("bp_b_ready", 64'(bus1.ex_ready),  64'd1);
    step();
    check("bp_c_out",   64'(bus1.mem_wdata), 64'd3);
    check("bp_c_wd",    64'(bus1.mem_wd),    64'd4);
    check("bp_c_valid", 64'(bus1.mem_valid), 64'd1);
    bus1.ex_valid = 1'b0;
    step();
    check("bp_empty", 64'(bus1.mem_valid), 64'd0);

    // Asynchronous reset in the middle of a held bundle
    bus1.mem_ready = 1'b0;
    push1(5'd9, 32'hE);
    step();
    bus1.ex_valid = 1'b0;
    check("mid_rst_pre", 64'(bus1.mem_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus1.mem_valid), 64'd0);
    check("mid_rst_wdata", 64'(bus1.mem_wdata), 64'd0);
    check("mid_rst_ready", 64'(bus1.ex_ready),  64'd1);
    @(negedge clk);
    rst = 1'b1;

    // Flush while M and S are both occupied and a new bundle is offered
    push1(5'd10, 32'hA);
    step();
    push1(5'd11, 32'hB);
    step();
    check("fl_pre_ready", 64'(bus1.ex_ready),  64'd0);
    check("fl_pre_mem",   64'(bus1.mem_wdata), 64'hA);
    push1(5'd12, 32'hD);
    flush = 1'b1;
    step();
    check("fl_valid", 64'(bus1.mem_valid), 64'd0);
    check("fl_wreg",  64'(bus1.mem_wreg),  64'd0);
    check("fl_ready", 64'(bus1.ex_ready),  64'd1);
    flush = 1'b0;
    bus1.ex_valid = 1'b0;
    bus1.mem_ready = 1'b1;
    step();
    check("fl_no_d_1", 64'(bus1.mem_valid), 64'd0);
    step();
    check("fl_no_d_2", 64'(bus1.mem_valid), 64'd0);

`ifdef EX_MEM_STALL_CNT_EN
    // Stall counter: ten refused edges, then flush
    check("stall_start", 64'(stall_cnt1), 64'd0);
    bus1.mem_ready = 1'b0;
    push1(5'd2, 32'hF);
    step();
    bus1.ex_valid = 1'b0;
    for (int k = 0; k < 10; k++) step();
    check("stall_ten", 64'(stall_cnt1), 64'd10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("stall_flush", 64'(stall_cnt1), 64'd0);
    bus1.mem_ready = 1'b1;
`endif

    // Lane collision filter on the two-lane instance
    bus2.mem_ready = 1'b1;
    bus2.ex_valid  = 1'b1;
    bus2.ex_wd     = {5'd5, 5'd5};
    bus2.ex_wreg   = 2'b11;
    bus2.ex_wdata  = {32'hBBBB, 32'hAAAA};
    step();
    check("col_same_wreg",  64'(bus2.mem_wreg),  64'b10);
    check("col_same_wdata", 64'(bus2.mem_wdata), {32'hBBBB, 32'hAAAA});
    check("col_same_wd",    64'(bus2.mem_wd),    64'({5'd5, 5'd5}));
    bus2.ex_wd = {5'd6, 5'd5};
    step();
    check("col_diff_wreg", 64'(bus2.mem_wreg), 64'b11);
    check("col_diff_wd",   64'(bus2.mem_wd),   64'({5'd6, 5'd5}));
    bus2.ex_wd   = {5'd8, 5'd8};
    bus2.ex_wreg = 2'b01;
    step();
    check("col_off_wreg", 64'(bus2.mem_wreg), 64'b01);
    bus2.ex_valid = 1'b0;
    step();
    check("col_idle_wreg", 64'(bus2.mem_wreg), 64'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
